// File: rtl/exec_sequencer_if.sv
// Instruction-memory fetch port: req/ack handshake with a word address and a 32-bit read word.
interface exec_sequencer_if #(
  parameter int unsigned ADDR_W = 8
);
  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_ack;
  logic [31:0]       imem_rdata;

  modport master (output imem_req, imem_addr, input imem_ack, imem_rdata);
  modport slave  (input imem_req, imem_addr, output imem_ack, imem_rdata);
endinterface

// File: rtl/exec_sequencer.sv
// Multi-cycle fetch/execute sequencer: owns the PC, fetches over imem, strobes exec_en once per instruction.
// Optional single-step mode (input step, PAUSE state) is enabled by defining SEQ_STEP_EN.
module exec_sequencer #(
  parameter int unsigned ADDR_W  = 8,
  parameter logic [5:0]  HALT_OP = 6'b111111
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_pc,
`ifdef SEQ_STEP_EN
  input  logic              step,
`endif
  exec_sequencer_if.master  imem,
  output logic [31:0]       instr,
  output logic              exec_en,
  output logic [ADDR_W-1:0] pc,
  output logic              busy,
  output logic              halted,
  output logic [15:0]       instr_count
);

  localparam int unsigned CNT_W = 16;

`ifdef SEQ_STEP_EN
  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_EXEC, S_HALT, S_PAUSE} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_EXEC, S_HALT} state_t;
`endif

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_d;
  logic [CNT_W-1:0]  cnt_d;
  logic [31:0]       instr_d;
  logic [1:0]        sync_q;
  logic              run;

  // Reset release is re-timed through two flops before the FSM may move.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) sync_q <= 2'b00;
    else        sync_q <= {sync_q[0], 1'b1};
  end
  assign run = sync_q[1];

`ifdef SEQ_STEP_EN
  logic step_q;
  logic step_rise;
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) step_q <= 1'b0;
    else        step_q <= step;
  end
  assign step_rise = step & ~step_q;
`endif

  always_comb begin
    state_d = state_q;
    pc_d    = pc;
    cnt_d   = instr_count;
    instr_d = instr;
    case (state_q)
      S_IDLE, S_HALT: begin
        if (start) begin
          state_d = S_FETCH;
          pc_d    = start_pc;
          cnt_d   = '0;
        end
      end
      S_FETCH: begin
        if (imem.imem_ack) begin
          state_d = S_EXEC;
          instr_d = imem.imem_rdata;
        end
      end
      S_EXEC: begin
        if (instr[31:26] == HALT_OP) begin
          state_d = S_HALT;
        end else begin
`ifdef SEQ_STEP_EN
          state_d = S_PAUSE;
`else
          state_d = S_FETCH;
`endif
          pc_d    = pc + ADDR_W'(1);
          cnt_d   = (instr_count == {CNT_W{1'b1}}) ? instr_count : instr_count + CNT_W'(1);
        end
      end
`ifdef SEQ_STEP_EN
      S_PAUSE: begin
        if (step_rise) state_d = S_FETCH;
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  // All outputs are registered from the next-state values so they settle on the rising edge.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q        <= S_IDLE;
      pc             <= '0;
      instr_count    <= '0;
      instr          <= '0;
      exec_en        <= 1'b0;
      busy           <= 1'b0;
      halted         <= 1'b0;
      imem.imem_req  <= 1'b0;
      imem.imem_addr <= '0;
    end else if (run) begin
      state_q       <= state_d;
      pc            <= pc_d;
      instr_count   <= cnt_d;
      instr         <= instr_d;
      exec_en       <= (state_d == S_EXEC) && (instr_d[31:26] != HALT_OP);
      busy          <= (state_d == S_FETCH) || (state_d == S_EXEC);
      halted        <= (state_d == S_HALT);
      imem.imem_req <= (state_d == S_FETCH);
      if (state_d == S_FETCH) imem.imem_addr <= pc_d;
    end
  end

endmodule
